fir_mac_sequencer: RTL and testbench
====================================

Name: fir_mac_sequencer

Overview:
- Folded, time-multiplexed controller for the team's 16-bit sign-magnitude FIR.
- Replaces ORDER parallel multipliers with one shared multiply-accumulate, stepped through all taps by an FSM.
- Holds a programmable coefficient bank and a circular sample-history buffer.
- Sits between the slow-rate sample source and the filter-output consumer, with valid/ready handshakes on both sides.

Parameters:
- ORDER, 30, number of taps (2..32).
- ACC_W, 36, two's-complement accumulator width.
- ADDR_W, 5, coefficient/tap index width; must satisfy 2^ADDR_W >= ORDER.

Ports:
- clk_slow  in  1  sample-domain clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  16  sample, sign-magnitude: bit15 sign, [14:0] Q0.15 magnitude.
- out_valid  out  1  filtered result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  16  result, sign-magnitude, same format as in_data.
- cfg_we  in  1  coefficient write strobe.
- cfg_addr  in  ADDR_W  coefficient index.
- cfg_data  in  16  coefficient, sign-magnitude Q0.15.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- hist_clr  in  1  synchronous clear of sample history, honoured in IDLE only.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; in_ready=1; out_valid=0; out_data=0; cfg_err=0; busy=0; wr_ptr=0; accumulator=0; all coefficients and history entries=0.
- IDLE: in_ready=1.
  - in_valid=1: write in_data to hist[wr_ptr], clear the accumulator, tap index k=0, go to MAC.
  - hist_clr=1 with in_valid=0: zero all history and set wr_ptr=0.
  - hist_clr and in_valid together: the sample wins; hist_clr is ignored.
- MAC: ORDER cycles, one tap per cycle.
  - acc += sm2tc(coef[k] * hist[(wr_ptr-k) mod ORDER]); k increments each cycle.
  - Index wraps modulo ORDER, including when wr_ptr < k.
  - After tap ORDER-1: go to OUT, advance wr_ptr by 1 (wrapping from ORDER-1 to 0).
- OUT: register the formatted result and assert out_valid.
  - First out_valid cycle is the (ORDER+1)th edge after the accepting edge.
  - Hold out_data stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready: out_valid=0 next cycle, return to IDLE.
  - Peak throughput: one sample per ORDER+2 cycles.
- Multiply:
  - Product sign = sign XOR sign; product magnitude = 15x15 = 30 bits, Q0.30.
  - Zero magnitude yields +0 regardless of sign bits (0x8000 treated as zero).
  - Product is sign-extended to ACC_W in two's complement.
- Output formatting:
  - |acc| >= 2^30: magnitude saturates to 0x7FFF, sign preserved.
  - Otherwise magnitude = |acc|[29:15] (truncation).
  - A zero magnitude always outputs 0x0000 (never -0).
- Config writes:
  - Accepted only in IDLE; coefficient takes effect on the next sample.
  - cfg_we outside IDLE, or cfg_addr >= ORDER: write dropped, cfg_err pulses the next cycle.
  - cfg_we in the same IDLE cycle as sample acceptance: the write is accepted and used by that sample.
- Reset mid-MAC or mid-OUT: result discarded, everything returns to reset values, no out_valid pulse.

Optional Feature:
- Macro FIR_SEQ_ROUND_EN.
- Defined: round half-up on magnitude. Add 2^14 to |acc| before taking [29:15], then saturate (e.g. |acc|=2^30-1 rounds to 0x7FFF).
- Undefined: truncation exactly as in Behaviour.
- Latency is unchanged either way.

Decomposition:
- Shared package fir_seq_pkg holds:
  - state enum IDLE/MAC/OUT;
  - SM_W=16, PROD_W=31, sign-bit index 15;
  - saturation constant 15'h7FFF;
  - helper functions sm2tc and tc2sm_sat.
- One sub-module, fir_sm_mac: combinational sign-magnitude 16x16 multiply plus sign-extend to ACC_W.
- The FSM, accumulator register, history buffer and coefficient bank stay in fir_mac_sequencer.

Test Plan:
1. Impulse: program coef[k]=(k+1)<<6 for all k, send 0x7FFF then ORDER-1 zeros.
   - Output n equals truncation of 0x7FFF*coef[n]>>15; first out_valid 31 edges after acceptance for ORDER=30.
2. Wrap-around: send 45 constant samples 0x4000 with coef[0..29]=0x0400.
   - Outputs ramp, then steady at 30*0x0400*0x4000>>15 = 0x3C00 from sample 30 onward, with no glitch at the wr_ptr 29->0 wrap.
3. Backpressure: hold out_ready=0 for 10 cycles.
   - out_data stable, in_ready=0 throughout; one accept on release; next sample accepted the following cycle.
4. Saturation and signs: all coef=0x7FFF, all samples 0x7FFF → 0x7FFF. All samples 0xFFFF → 0xFFFF. Coef 0x8000 with a nonzero sample → output 0x0000.
5. Config protection: cfg_we during MAC → coefficient unchanged, cfg_err single pulse. cfg_addr=31 in IDLE → cfg_err pulse, no write.
6. Reset mid-MAC at tap 12: out_valid stays 0, busy=0 immediately, history reads zero. The next impulse gives coef[0] scaled, with no stale contribution.

Source files
------------

// File: rtl/fir_seq_pkg.sv
// Shared types, constants and sign-magnitude helpers for the folded FIR sequencer.
// FIR_SEQ_ROUND_EN: when defined, tc2sm_sat rounds half-up instead of truncating.
package fir_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int SM_W     = 16;
    localparam int PROD_W   = 31;
    localparam int SIGN_BIT = 15;

    localparam logic [14:0] SAT_MAG = 15'h7FFF;

    // Sign-magnitude Q0.15 x Q0.15 -> two's-complement Q0.30 (31 bits).
    // A zero magnitude becomes +0 whatever the sign bits say.
    function automatic logic [PROD_W-1:0] sm2tc(
        input logic [SM_W-1:0] a,
        input logic [SM_W-1:0] b
    );
        logic [29:0]       mag;
        logic [PROD_W-1:0] ext;
        mag = 30'(a[14:0]) * 30'(b[14:0]);
        ext = {1'b0, mag};
        if (a[SIGN_BIT] ^ b[SIGN_BIT]) begin
            return -ext;
        end
        return ext;
    endfunction

    // Accumulator magnitude (zero-extended) -> sign-magnitude Q0.15 with saturation.
    function automatic logic [SM_W-1:0] tc2sm_sat(
        input logic        neg,
        input logic [63:0] mag
    );
        logic [63:0] m;
        logic [14:0] r;
`ifdef FIR_SEQ_ROUND_EN
        m = mag + 64'd16384;
`else
        m = mag;
`endif
        if (m >= 64'h4000_0000) begin
            r = SAT_MAG;
        end else begin
            r = m[29:15];
        end
        if (r == 15'd0) begin
            return '0;
        end
        return {neg, r};
    endfunction

endpackage

// File: rtl/fir_sm_mac.sv
// Combinational sign-magnitude 16x16 multiply, sign-extended to the
// accumulator width.
module fir_sm_mac
    import fir_seq_pkg::*;
#(
    parameter int ACC_W = 36
) (
    input  logic [SM_W-1:0]  coef_i,
    input  logic [SM_W-1:0]  samp_i,
    output logic [ACC_W-1:0] prod_o
);

    logic [PROD_W-1:0] prod_tc;

    // Product in two's complement, then replicate its sign up to ACC_W.
    always_comb begin
        prod_tc = sm2tc(coef_i, samp_i);
        prod_o  = {{(ACC_W-PROD_W){prod_tc[PROD_W-1]}}, prod_tc};
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Folded FIR: one shared MAC stepped over ORDER taps by an IDLE/MAC/OUT FSM.
// FIR_SEQ_ROUND_EN: when defined, the result magnitude is rounded half-up.
module fir_mac_sequencer
    import fir_seq_pkg::*;
#(
    parameter int ORDER  = 30,
    parameter int ACC_W  = 36,
    parameter int ADDR_W = 5
) (
    input  logic              clk_slow,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [15:0]       cfg_data,
    output logic              cfg_err,
    input  logic              hist_clr,
    output logic              busy
);

    localparam int CNT_W = ADDR_W + 1;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [SM_W-1:0]   hist_q [ORDER];
    logic [SM_W-1:0]   hist_d [ORDER];
    logic [SM_W-1:0]   coef_q [ORDER];
    logic [SM_W-1:0]   coef_d [ORDER];
    logic [SM_W-1:0]   out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              cfg_err_q, cfg_err_d;

    logic              last_tap;
    logic              cfg_ok;
    logic [CNT_W-1:0]  rd_sum;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] wr_ptr_nxt;
    logic [ACC_W-1:0]  prod;
    logic [ACC_W-1:0]  acc_abs;
    logic [SM_W-1:0]   fmt_res;

    // Tap addressing: history index (wr_ptr - k) mod ORDER and pointer wrap.
    always_comb begin
        last_tap = (k_q == ADDR_W'(ORDER - 1));
        cfg_ok   = ({1'b0, cfg_addr} < CNT_W'(ORDER));
        if (k_q > wr_ptr_q) begin
            rd_sum = {1'b0, wr_ptr_q} + CNT_W'(ORDER) - {1'b0, k_q};
        end else begin
            rd_sum = {1'b0, wr_ptr_q} - {1'b0, k_q};
        end
        rd_idx = rd_sum[ADDR_W-1:0];
        if (wr_ptr_q == ADDR_W'(ORDER - 1)) begin
            wr_ptr_nxt = '0;
        end else begin
            wr_ptr_nxt = wr_ptr_q + ADDR_W'(1);
        end
    end

    fir_sm_mac #(
        .ACC_W (ACC_W)
    ) u_mac (
        .coef_i (coef_q[k_q]),
        .samp_i (hist_q[rd_idx]),
        .prod_o (prod)
    );

    // Result formatting from the finished accumulator.
    always_comb begin
        acc_abs = acc_q[ACC_W-1] ? -acc_q : acc_q;
        fmt_res = tc2sm_sat(acc_q[ACC_W-1], 64'(acc_abs));
    end

    // FSM state register.
    always_ff @(posedge clk_slow or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (in_valid) state_d = MAC;
            MAC:  if (last_tap) state_d = OUT;
            OUT:  if (out_valid_q && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = out_valid_q;
        out_data  = out_data_q;
        cfg_err   = cfg_err_q;
    end

    // Datapath next values: config, history, MAC step and output register.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        k_d         = k_q;
        acc_d       = acc_q;
        hist_d      = hist_q;
        coef_d      = coef_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        cfg_err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    if (cfg_ok) begin
                        coef_d[cfg_addr] = cfg_data;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
                if (in_valid) begin
                    hist_d[wr_ptr_q] = in_data;
                    acc_d            = '0;
                    k_d              = '0;
                end else if (hist_clr) begin
                    for (int i = 0; i < ORDER; i++) begin
                        hist_d[i] = '0;
                    end
                    wr_ptr_d = '0;
                end
            end
            MAC: begin
                cfg_err_d = cfg_we;
                acc_d     = acc_q + prod;
                k_d       = k_q + ADDR_W'(1);
                if (last_tap) begin
                    wr_ptr_d = wr_ptr_nxt;
                end
            end
            OUT: begin
                cfg_err_d = cfg_we;
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = fmt_res;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any result in flight.
    always_ff @(posedge clk_slow or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            for (int i = 0; i < ORDER; i++) begin
                hist_q[i] <= '0;
                coef_q[i] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            cfg_err_q   <= cfg_err_d;
            hist_q      <= hist_d;
            coef_q      <= coef_d;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer: sample-level FIR model plus literals.
module tb_fir_mac_sequencer;

    localparam int ORDER = 30;
    localparam int LAT   = ORDER + 1;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        cfg_we;
    logic [4:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        cfg_err;
    logic        hist_clr;
    logic        busy;

    fir_mac_sequencer #(
        .ORDER  (ORDER),
        .ACC_W  (36),
        .ADDR_W (5)
    ) dut (
        .clk_slow  (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .cfg_err   (cfg_err),
        .hist_clr  (hist_clr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] d;
        int          c;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] outs[$];
    logic [15:0] mcoef[ORDER];
    logic [15:0] mh[$];

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req,
                     $time);
        end
    endtask

    function automatic longint smv(input logic [15:0] x);
        longint m;
        m = longint'(x[14:0]);
        return x[15] ? -m : m;
    endfunction

    function automatic logic [15:0] fmt(input longint s);
        longint      m;
        logic [14:0] r;
        m = (s < 0) ? -s : s;
`ifdef FIR_SEQ_ROUND_EN
        m = m + 16384;
`endif
        if (m >= 64'sd1073741824) r = 15'h7FFF;
        else r = 15'(m >>> 15);
        if (r == 0) return 16'h0000;
        return {(s < 0), r};
    endfunction

    // y[n] = sum_j coef[j] * x[n-j], samples before the window or a clear are 0
    task automatic model_accept(input logic [15:0] d, input int c);
        longint s;
        exp_t   e;
        mh.push_front(d);
        if (mh.size() > ORDER) void'(mh.pop_back());
        s = 0;
        for (int j = 0; j < mh.size(); j++) begin
            s += smv(mcoef[j]) * smv(mh[j]);
        end
        e.d = fmt(s);
        e.c = c;
        expq.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < ORDER; i++) mcoef[i] = 16'h0000;
        mh.delete();
        expq.delete();
    endtask

    // Compare process: every cycle outside reset.
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic [15:0] pd = 16'h0000;
    always @(negedge clk) begin
        if (rst) begin
            check("ready_vs_busy", 16'(in_ready), 16'(!busy));
            if (out_valid) begin
                check("in_ready_while_valid", 16'(in_ready), 16'd0);
                if (!pv) begin
                    if (expq.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_valid: got %h required none",
                                 out_data);
                    end else begin
                        exp_t e;
                        e = expq.pop_front();
                        check("out_data", out_data, e.d);
                        check("latency", 16'(cyc - e.c), 16'(LAT));
                        outs.push_back(out_data);
                    end
                end else begin
                    check("hold_data", out_data, pd);
                    check("held_without_ready", 16'(pr), 16'd0);
                end
            end
            pv = out_valid;
            pd = out_data;
            pr = out_ready;
        end else begin
            pv = 1'b0;
        end
    end

    task automatic send(input logic [15:0] d, input bit clr, output int ac);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        hist_clr = clr;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            $display("FAIL send_timeout: in_ready got 0 required 1");
            miscompares++;
            vectors++;
            $display("== %0d vectors applied, %0d miscompares ==", vectors,
                     miscompares);
            $fatal(1, "stuck");
        end
        @(posedge clk);
        #1;
        ac = cyc;
        model_accept(d, ac);
        @(negedge clk);
        in_valid = 1'b0;
        hist_clr = 1'b0;
    endtask

    task automatic send_s(input logic [15:0] d);
        int ac;
        send(d, 1'b0, ac);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expq.size() != 0 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 2000) begin
            miscompares++;
            $display("FAIL drain_timeout: pending %0d required 0", expq.size());
            expq.delete();
        end
    endtask

    task automatic cfg_write(input int a, input logic [15:0] d, input bit idle);
        bit ok;
        ok       = idle && (a < ORDER);
        cfg_we   = 1'b1;
        cfg_addr = 5'(a);
        cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        if (ok) mcoef[a] = d;
        check("cfg_err", 16'(cfg_err), 16'(!ok));
        @(negedge clk);
        check("cfg_err_pulse", 16'(cfg_err), 16'd0);
    endtask

    task automatic clear_hist();
        hist_clr = 1'b1;
        @(negedge clk);
        hist_clr = 1'b0;
        mh.delete();
    endtask

    int ac;
    int c0;
    int n;

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = 16'h0000;
        out_ready = 1'b1;
        cfg_we = 1'b0;
        cfg_addr = 5'd0;
        cfg_data = 16'h0000;
        hist_clr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_in_ready", 16'(in_ready), 16'd1);
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_cfg_err", 16'(cfg_err), 16'd0);
        check("rst_busy", 16'(busy), 16'd0);
        rst = 1'b1;
        @(negedge clk);

        // Impulse; coef[0] written in the same cycle the impulse is accepted.
        for (int k = 1; k < ORDER; k++) cfg_write(k, 16'((k + 1) << 6), 1'b1);
        cfg_we = 1'b1;
        cfg_addr = 5'd0;
        cfg_data = 16'h0040;
        mcoef[0] = 16'h0040;
        send(16'h7FFF, 1'b0, ac);
        cfg_we = 1'b0;
        for (int i = 1; i < ORDER; i++) send_s(16'h0000);
        drain();
`ifndef FIR_SEQ_ROUND_EN
        check("imp_first", outs[0], 16'h003F);
        check("imp_last", outs[ORDER-1], 16'h077F);
`endif
        outs.delete();

        // Wrap-around ramp; sample 20 also raises hist_clr, which must lose.
        for (int k = 0; k < ORDER; k++) cfg_write(k, 16'h0400, 1'b1);
        clear_hist();
        for (int i = 0; i < 45; i++) send(16'h4000, (i == 20), ac);
        drain();
`ifndef FIR_SEQ_ROUND_EN
        check("wrap_first", outs[0], 16'h0200);
        check("wrap_steady30", outs[29], 16'h3C00);
        check("wrap_steady44", outs[44], 16'h3C00);
`endif
        outs.delete();

        // Backpressure: hold out_ready low 10 cycles.
        out_ready = 1'b0;
        send_s(16'h4000);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 16'(out_valid), 16'd1);
        repeat (10) begin
            @(negedge clk);
            check("bp_in_ready", 16'(in_ready), 16'd0);
            check("bp_valid", 16'(out_valid), 16'd1);
        end
        out_ready = 1'b1;
        c0 = cyc;
        send(16'h4000, 1'b0, ac);
        check("bp_accept_cycle", 16'(ac - c0), 16'd2);
        drain();
        outs.delete();

        // Saturation and signs.
        for (int k = 0; k < ORDER; k++) cfg_write(k, 16'h7FFF, 1'b1);
        clear_hist();
        for (int i = 0; i < 3; i++) send_s(16'h7FFF);
        drain();
        check("sat_pos", outs[2], 16'h7FFF);
        clear_hist();
        send_s(16'hFFFF);
        send_s(16'hFFFF);
        drain();
        check("sat_neg", outs[4], 16'hFFFF);
        for (int k = 0; k < ORDER; k++) cfg_write(k, 16'h8000, 1'b1);
        send_s(16'h1234);
        drain();
        check("neg_zero_coef", outs[5], 16'h0000);
        cfg_write(0, 16'h4000, 1'b1);
        clear_hist();
        send_s(16'h8001);
        drain();
`ifndef FIR_SEQ_ROUND_EN
        check("no_minus_zero", outs[6], 16'h0000);
`endif
        outs.delete();

        // Config protection.
        send_s(16'h4000);
        cfg_write(0, 16'h1111, 1'b0);
        drain();
        cfg_write(31, 16'h2222, 1'b1);
        clear_hist();
        send_s(16'h7FFF);
        drain();
`ifndef FIR_SEQ_ROUND_EN
        check("coef_protected", outs[1], 16'h3FFF);
`endif
        outs.delete();

        // Reset in the middle of the MAC sweep.
        send_s(16'h7FFF);
        repeat (12) @(posedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("mid_rst_busy", 16'(busy), 16'd0);
        check("mid_rst_valid", 16'(out_valid), 16'd0);
        check("mid_rst_ready", 16'(in_ready), 16'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_no_out", 16'(outs.size()), 16'd0);
        for (int k = 0; k < ORDER; k++) cfg_write(k, 16'((k + 1) << 6), 1'b1);
        send_s(16'h7FFF);
        drain();
`ifndef FIR_SEQ_ROUND_EN
        check("post_rst_impulse", outs[0], 16'h003F);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors,
                 miscompares);
        $finish;
    end

endmodule
